mem_port_arbiter: RTL and testbench

- Shares the single synchronous byte-addressed memory between an instruction-fetch requester (I) and a load/store requester (D).
- Each request and each response uses a valid/ready handshake.
- The block arbitrates between I and D, sequences one memory access at a time, and sign- or zero-extends sub-word loads.
- It sits between the core's fetch/LSU stages and the memory; it is the only driver of the memory's control inputs.

---
 rtl/mem_port_arbiter_pkg.sv | 42 ++++
 rtl/mem_port_arbiter_rr_arb2.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types, unit codes and helpers for the I/D memory port arbiter.
// Provides fallback ADDR_WIDTH / WORD_WIDTH defines when no common defs are present.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

package mem_arb_pkg;

  localparam int DEF_WORD_WIDTH = 32;

  localparam logic [1:0] BYTE_MEMORY_MODE     = 2'b00;
  localparam logic [1:0] HALFWORD_MEMORY_MODE = 2'b01;
  localparam logic [1:0] WORD_MEMORY_MODE     = 2'b10;
  localparam logic [1:0] ILLEGAL_MEMORY_MODE  = 2'b11;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  // Sub-word loads arrive in the low bits of the memory word.
  function automatic logic [DEF_WORD_WIDTH-1:0] extend(
    input logic [1:0]                unit,
    input logic                      sgn,
    input logic [DEF_WORD_WIDTH-1:0] word
  );
    logic [DEF_WORD_WIDTH-1:0] res;
    case (unit)
      BYTE_MEMORY_MODE:     res = {{(DEF_WORD_WIDTH-8){sgn & word[7]}}, word[7:0]};
      HALFWORD_MEMORY_MODE: res = {{(DEF_WORD_WIDTH-16){sgn & word[15]}}, word[15:0]};
      default:              res = word;
    endcase
    return res;
  endfunction

  function automatic logic misaligned(input logic [1:0] unit, input logic [1:0] lo);
    return ((unit == HALFWORD_MEMORY_MODE) && lo[0]) ||
           ((unit == WORD_MEMORY_MODE) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port not granted last time wins.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req_fetch,
  input  logic req_data,
  output logic grant_fetch,
  output logic grant_data
);

  owner_t last_q;

  always_comb begin
    grant_fetch = 1'b0;
    grant_data  = 1'b0;
    if (en) begin
      if (req_fetch && req_data) begin
        if (last_q == OWN_I) grant_data = 1'b1;
        else                 grant_fetch = 1'b1;
      end else begin
        grant_fetch = req_fetch;
        grant_data  = req_data;
      end
    end
  end

  // Reset to OWN_I so the data port wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_I;
    end else if (grant_data) begin
      last_q <= OWN_D;
    end else if (grant_fetch) begin
      last_q <= OWN_I;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous byte-addressed memory between fetch (I) and load/store (D) ports,
// one access at a time. Define MEM_ARB_MISALIGN_CHECK_EN to trap misaligned accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = `ADDR_WIDTH,
  parameter int WORD_WIDTH = `WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iReqValid,
  output logic                  iReqReady,
  input  logic [ADDR_WIDTH-1:0] iAddr,
  output logic                  iRspValid,
  input  logic                  iRspReady,
  output logic [WORD_WIDTH-1:0] iRspData,
  output logic                  iRspErr,
  input  logic                  dReqValid,
  output logic                  dReqReady,
  input  logic                  dReqWrite,
  input  logic [1:0]            dReqUnit,
  input  logic                  dReqSigned,
  input  logic [ADDR_WIDTH-1:0] dAddr,
  input  logic [WORD_WIDTH-1:0] dWData,
  output logic                  dRspValid,
  input  logic                  dRspReady,
  output logic [WORD_WIDTH-1:0] dRspData,
  output logic                  dRspErr,
  output logic                  memRead,
  output logic                  memWrite,
  output logic [1:0]            addrUnit,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [WORD_WIDTH-1:0] dataIn,
  input  logic [WORD_WIDTH-1:0] memDataOut,
  output state_t                dbg_state
);

  // Handshake: a request or response transfers on a rising edge where valid and
  // ready are both high; requesters hold valid and fields stable until then.

  state_t                state_q, state_d;
  owner_t                owner_q;
  logic                  write_q, signed_q, err_q;
  logic [1:0]            unit_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WORD_WIDTH-1:0] wdata_q;

  logic                  arb_en, grant_fetch, grant_data, accept;
  logic                  i_err, d_err, acc_err;
  logic [WORD_WIDTH-1:0] load_data, rsp_data;

  assign arb_en = rst_n && (state_q == IDLE);

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (arb_en),
    .req_fetch   (iReqValid),
    .req_data    (dReqValid),
    .grant_fetch (grant_fetch),
    .grant_data  (grant_data)
  );

  assign accept    = grant_fetch | grant_data;
  assign iReqReady = grant_fetch;
  assign dReqReady = grant_data;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign i_err = misaligned(WORD_MEMORY_MODE, iAddr[1:0]);
  assign d_err = (dReqUnit == ILLEGAL_MEMORY_MODE) || misaligned(dReqUnit, dAddr[1:0]);
`else
  assign i_err = 1'b0;
  assign d_err = (dReqUnit == ILLEGAL_MEMORY_MODE);
`endif

  assign acc_err = grant_data ? d_err : i_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Command capture; only written on the accept edge, so it stays stable for ISSUE and RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_I;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      unit_q   <= BYTE_MEMORY_MODE;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (grant_data) begin
      owner_q  <= OWN_D;
      write_q  <= dReqWrite;
      signed_q <= dReqSigned;
      err_q    <= d_err;
      unit_q   <= dReqUnit;
      addr_q   <= dAddr;
      wdata_q  <= dWData;
    end else if (grant_fetch) begin
      owner_q  <= OWN_I;
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= i_err;
      unit_q   <= WORD_MEMORY_MODE;
      addr_q   <= iAddr;
      wdata_q  <= '0;
    end
  end

  // memDataOut holds the last read word through RESP since no other read can start.
  assign load_data = extend(unit_q, signed_q, memDataOut);
  assign rsp_data  = (write_q || err_q) ? '0 : load_data;

  always_comb begin
    state_d   = state_q;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    addrUnit  = 2'b00;
    address   = '0;
    dataIn    = '0;
    iRspValid = 1'b0;
    iRspData  = '0;
    iRspErr   = 1'b0;
    dRspValid = 1'b0;
    dRspData  = '0;
    dRspErr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = acc_err ? RESP : ISSUE;
      end
      ISSUE: begin
        memRead  = !write_q;
        memWrite = write_q;
        addrUnit = unit_q;
        address  = addr_q;
        dataIn   = write_q ? wdata_q : '0;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q == OWN_D) begin
          dRspValid = 1'b1;
          dRspData  = rsp_data;
          dRspErr   = err_q;
          if (dRspReady) state_d = IDLE;
        end else begin
          iRspValid = 1'b1;
          iRspData  = rsp_data;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
          iRspErr   = err_q;
`else
          iRspErr   = 1'b0;
`endif
          if (iRspReady) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses on accept,
// a negedge monitor checks arbitration, memory pulses, latency and response data.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW      = 32;
  localparam int WW      = 32;
  localparam int TIMEOUT = 200;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          iReqValid, iReqReady, iRspValid, iRspReady, iRspErr;
  logic [AW-1:0] iAddr;
  logic [WW-1:0] iRspData;
  logic          dReqValid, dReqReady, dReqWrite, dReqSigned, dRspValid, dRspReady, dRspErr;
  logic [1:0]    dReqUnit;
  logic [AW-1:0] dAddr;
  logic [WW-1:0] dWData, dRspData;
  logic          memRead, memWrite;
  logic [1:0]    addrUnit;
  logic [AW-1:0] address;
  logic [WW-1:0] dataIn;
  logic [WW-1:0] memDataOut = '0;
  state_t        dbg_state;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clk(clk), .rst_n(rst_n),
    .iReqValid(iReqValid), .iReqReady(iReqReady), .iAddr(iAddr),
    .iRspValid(iRspValid), .iRspReady(iRspReady), .iRspData(iRspData), .iRspErr(iRspErr),
    .dReqValid(dReqValid), .dReqReady(dReqReady), .dReqWrite(dReqWrite),
    .dReqUnit(dReqUnit), .dReqSigned(dReqSigned), .dAddr(dAddr), .dWData(dWData),
    .dRspValid(dRspValid), .dRspReady(dRspReady), .dRspData(dRspData), .dRspErr(dRspErr),
    .memRead(memRead), .memWrite(memWrite), .addrUnit(addrUnit), .address(address),
    .dataIn(dataIn), .memDataOut(memDataOut), .dbg_state(dbg_state)
  );

  // memory seen by the DUT (256 bytes, little-endian, address wraps)
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  always @(posedge clk) begin
    if (memWrite) begin
      mem[address[7:0]] = dataIn[7:0];
      if (addrUnit != 2'b00) mem[address[7:0] + 8'd1] = dataIn[15:8];
      if (addrUnit == 2'b10) begin
        mem[address[7:0] + 8'd2] = dataIn[23:16];
        mem[address[7:0] + 8'd3] = dataIn[31:24];
      end
    end
    if (memRead) begin
      case (addrUnit)
        2'b00:   memDataOut <= {24'h0, mem[address[7:0]]};
        2'b01:   memDataOut <= {16'h0, mem[address[7:0] + 8'd1], mem[address[7:0]]};
        default: memDataOut <= {mem[address[7:0] + 8'd3], mem[address[7:0] + 8'd2],
                                mem[address[7:0] + 8'd1], mem[address[7:0]]};
      endcase
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_fail = 0;
  logic [WW:0] exp_i_q[$];
  logic [WW:0] exp_d_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: bytes in an array, results by plain arithmetic
  function automatic bit model_bad(input logic [1:0] unit, input logic [AW-1:0] a);
    if (unit == 2'd3) return 1'b1;
    return MIS_EN && ((int'(a[1:0]) % (1 << unit)) != 0);
  endfunction

  function automatic logic [WW:0] model_access(input logic wr, input logic [1:0] unit,
                                               input logic sgn, input logic [AW-1:0] a,
                                               input logic [WW-1:0] wd);
    int unsigned v;
    int nbytes;
    if (model_bad(unit, a)) return {1'b1, 32'h0};
    nbytes = 1 << unit;
    if (wr) begin
      for (int k = 0; k < nbytes; k++) ref_mem[8'(int'(a[7:0]) + k)] = wd[8*k +: 8];
      return {1'b0, 32'h0};
    end
    v = 0;
    for (int k = 0; k < nbytes; k++) v += 32'(ref_mem[8'(int'(a[7:0]) + k)]) << (8 * k);
    if (sgn && nbytes < 4 && v >= (32'd1 << (8 * nbytes - 1))) v = v - (32'd1 << (8 * nbytes));
    return {1'b0, v};
  endfunction

  // driver tasks
  task automatic drive_i(input logic [AW-1:0] a);
    int n;
    bit done;
    @(posedge clk); #1;
    iAddr = a;
    iReqValid = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < TIMEOUT) begin
      @(negedge clk);
      if (iReqReady) begin
        exp_i_q.push_back(model_access(1'b0, WORD_MEMORY_MODE, 1'b0, a, '0));
        done = 1;
      end else n++;
    end
    if (!done) check("i_accept_timeout", 64'(iReqReady), 64'(1));
    @(posedge clk); #1;
    iReqValid = 1'b0;
  endtask

  task automatic drive_d(input logic wr, input logic [1:0] unit, input logic sgn,
                         input logic [AW-1:0] a, input logic [WW-1:0] wd);
    int n;
    bit done;
    @(posedge clk); #1;
    dReqWrite = wr; dReqUnit = unit; dReqSigned = sgn; dAddr = a; dWData = wd;
    dReqValid = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < TIMEOUT) begin
      @(negedge clk);
      if (dReqReady) begin
        exp_d_q.push_back(model_access(wr, unit, sgn, a, wd));
        done = 1;
      end else n++;
    end
    if (!done) check("d_accept_timeout", 64'(dReqReady), 64'(1));
    @(posedge clk); #1;
    dReqValid = 1'b0;
  endtask

  // store interrupted by reset during its ISSUE cycle: no expectation is pushed
  task automatic reset_mid_store();
    int n;
    bit done;
    @(posedge clk); #1;
    dReqWrite = 1'b1; dReqUnit = WORD_MEMORY_MODE; dReqSigned = 1'b0;
    dAddr = 32'h30; dWData = 32'hCAFEF00D; dReqValid = 1'b1;
    n = 0;
    done = 0;
    while (!done && n < TIMEOUT) begin
      @(negedge clk);
      if (dReqReady) done = 1;
      else n++;
    end
    if (!done) check("rst_store_accept_timeout", 64'(dReqReady), 64'(1));
    @(posedge clk); #1;
    dReqValid = 1'b0;
    check("issue_state", 64'(dbg_state), 64'(ISSUE));
    check("issue_mem_write", 64'(memWrite), 64'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mem_write_drop", 64'({memRead, memWrite}), 64'(0));
    check("rst_state_idle", 64'(dbg_state), 64'(IDLE));
    check("rst_no_rsp", 64'({iRspValid, dRspValid}), 64'(0));
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // monitor: high-level model of the single outstanding transaction
  bit            busy = 0, last_d = 0, own_d = 0, m_err = 0, m_wr = 0;
  int            cyc = 0, lat = 0;
  logic [1:0]    m_unit;
  logic [AW-1:0] m_addr;
  logic [WW-1:0] m_wd;

  always @(negedge clk) begin
    bit want_i, want_d, ov, oo, ordy, oerr;
    logic [WW-1:0] odata;
    logic [WW:0] e;
    if (!rst_n) begin
      busy = 0;
      last_d = 0;
    end else if (!busy) begin
      if (iReqValid && dReqValid) begin
        want_d = !last_d;
        want_i = last_d;
      end else begin
        want_i = iReqValid;
        want_d = dReqValid;
      end
      check("i_req_ready", 64'(iReqReady), 64'(want_i));
      check("d_req_ready", 64'(dReqReady), 64'(want_d));
      check("idle_rsp_valid", 64'({iRspValid, dRspValid}), 64'(0));
      check("idle_mem_ctrl", 64'({memRead, memWrite}), 64'(0));
      if (want_i || want_d) begin
        busy = 1; cyc = 0; own_d = want_d; last_d = want_d;
        if (want_d) begin
          m_wr = dReqWrite; m_unit = dReqUnit; m_addr = dAddr; m_wd = dWData;
        end else begin
          m_wr = 1'b0; m_unit = WORD_MEMORY_MODE; m_addr = iAddr; m_wd = '0;
        end
        m_err = model_bad(m_unit, m_addr);
        lat = m_err ? 1 : 2;
      end
    end else begin
      cyc++;
      check("busy_req_ready", 64'({iReqReady, dReqReady}), 64'(0));
      if (cyc == 1 && !m_err) begin
        check("mem_read", 64'(memRead), 64'(!m_wr));
        check("mem_write", 64'(memWrite), 64'(m_wr));
        check("mem_address", 64'(address), 64'(m_addr));
        check("mem_unit", 64'(addrUnit), 64'(m_unit));
        if (m_wr) check("mem_data_in", 64'(dataIn), 64'(m_wd));
      end else begin
        check("mem_ctrl_quiet", 64'({memRead, memWrite}), 64'(0));
      end
      ov    = own_d ? dRspValid : iRspValid;
      oo    = own_d ? iRspValid : dRspValid;
      ordy  = own_d ? dRspReady : iRspReady;
      oerr  = own_d ? dRspErr : iRspErr;
      odata = own_d ? dRspData : iRspData;
      check("rsp_valid_timing", 64'(ov), 64'(cyc >= lat));
      check("other_rsp_valid", 64'(oo), 64'(0));
      if (ov && ordy) begin
        if ((own_d ? exp_d_q.size() : exp_i_q.size()) == 0) begin
          check("rsp_unexpected", 64'(ov), 64'(0));
        end else begin
          e = own_d ? exp_d_q.pop_front() : exp_i_q.pop_front();
          check(own_d ? "d_rsp" : "i_rsp", 64'({oerr, odata}), 64'(e));
        end
        busy = 0;
      end
    end
  end

  // random response backpressure
  initial begin
    iRspReady = 1'b0;
    dRspReady = 1'b0;
    forever begin
      @(posedge clk); #1;
      iRspReady = ($urandom_range(0, 3) != 0);
      dRspReady = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    int n;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    mem[8'h10] = 8'hF1; mem[8'h11] = 8'hF0; mem[8'h12] = 8'h81; mem[8'h13] = 8'h80;
    ref_mem[8'h10] = 8'hF1; ref_mem[8'h11] = 8'hF0; ref_mem[8'h12] = 8'h81; ref_mem[8'h13] = 8'h80;

    rst_n = 1'b0;
    iReqValid = 1'b1; iAddr = 32'h10;
    dReqValid = 1'b1; dReqWrite = 1'b1; dReqUnit = 2'b10; dReqSigned = 1'b0;
    dAddr = 32'h20; dWData = 32'h1234_5678;
    #12;
    check("rst_req_ready", 64'({iReqReady, dReqReady}), 64'(0));
    check("rst_rsp_valid", 64'({iRspValid, dRspValid}), 64'(0));
    check("rst_rsp_err", 64'({iRspErr, dRspErr}), 64'(0));
    check("rst_rsp_data", {iRspData, dRspData}, 64'(0));
    check("rst_mem_ctrl", 64'({memRead, memWrite, addrUnit}), 64'(0));
    check("rst_mem_bus", {address, dataIn}, 64'(0));
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    iReqValid = 1'b0;
    dReqValid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // simultaneous requests straight after reset: D, I, D, I
    fork
      begin
        drive_d(1'b0, WORD_MEMORY_MODE, 1'b0, 32'h10, '0);
        drive_d(1'b0, BYTE_MEMORY_MODE, 1'b1, 32'h12, '0);
      end
      begin
        drive_i(32'h10);
        drive_i(32'h14);
      end
    join

    // directed: fetch, sub-word loads, store then fetch, errors
    drive_i(32'h10);
    drive_d(1'b0, BYTE_MEMORY_MODE, 1'b1, 32'h10, '0);
    drive_d(1'b0, BYTE_MEMORY_MODE, 1'b0, 32'h10, '0);
    drive_d(1'b0, HALFWORD_MEMORY_MODE, 1'b1, 32'h12, '0);
    drive_d(1'b0, HALFWORD_MEMORY_MODE, 1'b0, 32'h12, '0);
    drive_d(1'b1, WORD_MEMORY_MODE, 1'b0, 32'h20, 32'hDEADBEEF);
    drive_i(32'h20);
    drive_d(1'b0, 2'b11, 1'b0, 32'h20, '0);
    drive_d(1'b1, 2'b11, 1'b0, 32'h24, 32'h5555_AAAA);
    drive_d(1'b0, WORD_MEMORY_MODE, 1'b0, 32'h13, '0);
    drive_d(1'b0, HALFWORD_MEMORY_MODE, 1'b1, 32'h11, '0);
    drive_i(32'h13);

    // randomized concurrent traffic
    fork
      begin
        for (int t = 0; t < 30; t++) begin
          drive_d(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom));
        end
      end
      begin
        for (int t = 0; t < 30; t++) begin
          drive_i(($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & ~32'h3));
        end
      end
    join

    // reset during a store's ISSUE cycle, then normal service
    b = ref_mem[8'h30];
    reset_mid_store();
    drive_i(32'h30);
    drive_d(1'b0, BYTE_MEMORY_MODE, 1'b0, 32'h30, '0);
    check("rst_store_not_written", 64'(mem[8'h30]), 64'(b));

    n = 0;
    while ((busy || exp_i_q.size() != 0 || exp_d_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", 64'(busy), 64'(0));
    check("drain_queues", 64'(exp_i_q.size() + exp_d_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
